// File: rtl/morse_encoder.sv
// rtl/morse_encoder.sv - ASCII to Morse pulse transmitter (dot/dash/char space/word space)
module morse_encoder #(
    parameter int PULSE_CYCLES = 1,
    parameter int GAP_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       dot_out,
    output logic       dash_out,
    output logic       char_space_out,
    output logic       word_space_out,
    output logic       err,
    output logic       busy
);

    localparam int MAXC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] P_LAST = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] G_LAST = CW'(GAP_CYCLES - 1);

    localparam logic [1:0] K_ERR = 2'd0;
    localparam logic [1:0] K_SYM = 2'd1;
    localparam logic [1:0] K_WSP = 2'd2;

    typedef enum logic [2:0] {IDLE, SYM, SGAP, CSPACE, WSPACE, FGAP, ERR} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [4:0]    pat, pat_nxt;
    logic          dot_nxt, dash_nxt, cs_nxt, ws_nxt, err_nxt;

    logic [7:0]    ch;
    logic [1:0]    lk_kind;
    logic [2:0]    lk_len;
    logic [4:0]    lk_pat;

    // Case-fold lower case and look the character up in the ITU table (1 = dash, first symbol at bit len-1)
    always_comb begin
        ch = din;
        if (din >= 8'h61 && din <= 8'h7A) ch = din - 8'h20;
        {lk_kind, lk_len, lk_pat} = {K_ERR, 3'd0, 5'b00000};
        case (ch)
            8'h20: {lk_kind, lk_len, lk_pat} = {K_WSP, 3'd0, 5'b00000};
            8'h41: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd2, 5'b00001};
            8'h42: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd4, 5'b01000};
            8'h43: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd4, 5'b01010};
            8'h44: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd3, 5'b00100};
            8'h45: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd1, 5'b00000};
            8'h46: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd4, 5'b00010};
            8'h47: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd3, 5'b00110};
            8'h48: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd4, 5'b00000};
            8'h49: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd2, 5'b00000};
            8'h4A: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd4, 5'b00111};
            8'h4B: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd3, 5'b00101};
            8'h4C: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd4, 5'b00100};
            8'h4D: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd2, 5'b00011};
            8'h4E: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd2, 5'b00010};
            8'h4F: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd3, 5'b00111};
            8'h50: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd4, 5'b00110};
            8'h51: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd4, 5'b01101};
            8'h52: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd3, 5'b00010};
            8'h53: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd3, 5'b00000};
            8'h54: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd1, 5'b00001};
            8'h55: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd3, 5'b00001};
            8'h56: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd4, 5'b00001};
            8'h57: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd3, 5'b00011};
            8'h58: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd4, 5'b01001};
            8'h59: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd4, 5'b01011};
            8'h5A: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd4, 5'b01100};
            8'h30: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd5, 5'b11111};
            8'h31: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd5, 5'b01111};
            8'h32: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd5, 5'b00111};
            8'h33: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd5, 5'b00011};
            8'h34: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd5, 5'b00001};
            8'h35: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd5, 5'b00000};
            8'h36: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd5, 5'b10000};
            8'h37: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd5, 5'b11000};
            8'h38: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd5, 5'b11100};
            8'h39: {lk_kind, lk_len, lk_pat} = {K_SYM, 3'd5, 5'b11110};
            default: ;
        endcase
    end

    // Next-state logic; outputs are derived from the next state so they can be registered
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        idx_nxt   = idx;
        pat_nxt   = pat;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (din_valid) begin
                    if (lk_kind == K_SYM) begin
                        state_nxt = SYM;
                        idx_nxt   = lk_len - 3'd1;
                        pat_nxt   = lk_pat;
                    end else if (lk_kind == K_WSP) begin
                        state_nxt = WSPACE;
                    end else begin
                        state_nxt = ERR;
                    end
                end
            end
            SYM: if (cnt == P_LAST) begin
                state_nxt = SGAP;
                cnt_nxt   = '0;
            end
            SGAP: if (cnt == G_LAST) begin
                cnt_nxt = '0;
                if (idx == 3'd0) begin
                    state_nxt = CSPACE;
                end else begin
                    state_nxt = SYM;
                    idx_nxt   = idx - 3'd1;
                end
            end
            CSPACE, WSPACE: if (cnt == P_LAST) begin
                state_nxt = FGAP;
                cnt_nxt   = '0;
            end
            FGAP: if (cnt == G_LAST) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        dot_nxt  = (state_nxt == SYM) && !pat_nxt[idx_nxt];
        dash_nxt = (state_nxt == SYM) &&  pat_nxt[idx_nxt];
        cs_nxt   = (state_nxt == CSPACE);
        ws_nxt   = (state_nxt == WSPACE);
        err_nxt  = (state_nxt == ERR);
    end

    // State, counters and registered pulse outputs; reset abandons any character in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            cnt            <= '0;
            idx            <= '0;
            pat            <= '0;
            dot_out        <= 1'b0;
            dash_out       <= 1'b0;
            char_space_out <= 1'b0;
            word_space_out <= 1'b0;
            err            <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            idx            <= idx_nxt;
            pat            <= pat_nxt;
            dot_out        <= dot_nxt;
            dash_out       <= dash_nxt;
            char_space_out <= cs_nxt;
            word_space_out <= ws_nxt;
            err            <= err_nxt;
        end
    end

    assign din_ready = (state == IDLE);
    assign busy      = ~din_ready;

endmodule

// File: tb/tb_morse_encoder.sv
// tb/tb_morse_encoder.sv - directed self-checking bench for morse_encoder
module tb_morse_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready, dot_out, dash_out, char_space_out, word_space_out, err, busy;

    int  n_cmp = 0;
    int  n_err = 0;
    byte obs [0:63];
    int  acc_edge [0:3];
    int  acc_n;
    logic pre_ready;
    logic [7:0] next_ch;

    morse_encoder #(.PULSE_CYCLES(1), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .dot_out(dot_out), .dash_out(dash_out), .char_space_out(char_space_out),
        .word_space_out(word_space_out), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    // One character per cycle: D dot, H dash, C char space, W word space, E err,
    // R idle/ready, . busy with no pulse, X overlapping pulses, B busy/ready disagree
    function automatic byte code();
        int n;
        n = int'(dot_out) + int'(dash_out) + int'(char_space_out) + int'(word_space_out) + int'(err);
        if (busy === din_ready) return "B";
        if (n > 1) return "X";
        if (dot_out) return "D";
        if (dash_out) return "H";
        if (char_space_out) return "C";
        if (word_space_out) return "W";
        if (err) return "E";
        return din_ready ? "R" : ".";
    endfunction

    task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed 0x%02h expected 0x%02h", tag, o, e);
        end
    endtask

    task automatic check_trace(input string tag, input string exp);
        for (int i = 0; i < exp.len(); i++) begin
            n_cmp++;
            assert (obs[i] === exp[i]) else begin
                n_err++;
                $error("FAIL %s c%0d observed %c expected %c", tag, i + 1, obs[i], exp[i]);
            end
        end
    endtask

    task automatic run_char(input logic [7:0] c, input int n);
        @(negedge clk);
        chk("ready_before_accept", {7'd0, din_ready}, 8'd1);
        din = c;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din = 8'h45;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            obs[k] = code();
        end
    endtask

    initial begin
        rst = 1'b0;
        din = 8'h54;
        din_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pulses", {3'd0, dot_out, dash_out, char_space_out, word_space_out, err}, 8'd0);
        chk("rst_ready", {7'd0, din_ready}, 8'd1);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        din_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        run_char(8'h45, 7);  check_trace("E", "D..C..R");
        run_char(8'h61, 10); check_trace("a_lower", "D..H..C..R");
        run_char(8'h41, 10); check_trace("A_upper", "D..H..C..R");
        run_char(8'h30, 19); check_trace("digit0", "H..H..H..H..H..C..R");
        run_char(8'h20, 4);  check_trace("space", "W..R");
        run_char(8'h23, 2);  check_trace("hash_err", "ER");
        run_char(8'h35, 19); check_trace("digit5", "D..D..D..D..D..C..R");

        // SOS with din_valid held high; din advances right after each accept edge
        @(negedge clk);
        din = 8'h53;
        din_valid = 1'b1;
        acc_n = 0;
        for (int k = 0; k < 39; k++) begin
            pre_ready = din_ready;
            @(posedge clk);
            if (pre_ready && din_valid) begin
                acc_edge[acc_n] = k;
                acc_n++;
                #1;
                next_ch = (acc_n == 1) ? 8'h4F : 8'h53;
                if (acc_n < 3) din = next_ch;
                else din_valid = 1'b0;
            end
            @(negedge clk);
            obs[k] = code();
        end
        din_valid = 1'b0;
        chk("sos_accepts", 8'(acc_n), 8'd3);
        chk("sos_gap1", 8'(acc_edge[1] - acc_edge[0]), 8'd13);
        chk("sos_gap2", 8'(acc_edge[2] - acc_edge[1]), 8'd13);
        check_trace("SOS", "D..D..D..C..RH..H..H..C..RD..D..D..C..R");

        // Reset in the middle of 'S' (c5), then confirm no trailing char space
        run_char(8'h53, 4);
        check_trace("S_pre_rst", "D..D");
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_pulses", {3'd0, dot_out, dash_out, char_space_out, word_space_out, err}, 8'd0);
        chk("midrst_ready", {7'd0, din_ready}, 8'd1);
        chk("midrst_busy", {7'd0, busy}, 8'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            obs[k] = code();
        end
        check_trace("post_rst_idle", "RRRRRRRR");
        run_char(8'h54, 7); check_trace("T_after_rst", "H..C..R");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
